// File: rtl/sram_axi_bridge_mp.sv
// rtl/sram_axi_bridge_mp.sv - NUM_PORTS SRAM-like masters onto one AXI3 master, reads pipelined, writes serial
// SRAM_AXI_RR_ARB_EN selects round-robin grant; undefined gives fixed priority (highest index wins).
module sram_axi_bridge_mp #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int MAX_RD    = 4
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS-1:0]        wr,
    input  logic [3*NUM_PORTS-1:0]      size,
    input  logic [ADDR_W*NUM_PORTS-1:0] addr,
    input  logic [32*NUM_PORTS-1:0]     wdata,
    output logic [32*NUM_PORTS-1:0]     rdata,
    output logic [NUM_PORTS-1:0]        addr_ok,
    output logic [NUM_PORTS-1:0]        data_ok,
    output logic [3:0]                  arid,
    output logic [ADDR_W-1:0]           araddr,
    output logic [3:0]                  arlen,
    output logic [2:0]                  arsize,
    output logic [1:0]                  arburst,
    output logic [1:0]                  arlock,
    output logic [3:0]                  arcache,
    output logic [2:0]                  arprot,
    output logic                        arvalid,
    input  logic                        arready,
    input  logic [3:0]                  rid,
    input  logic [31:0]                 rdata_axi,
    input  logic [1:0]                  rresp,
    input  logic                        rlast,
    input  logic                        rvalid,
    output logic                        rready,
    output logic [3:0]                  awid,
    output logic [ADDR_W-1:0]           awaddr,
    output logic [3:0]                  awlen,
    output logic [2:0]                  awsize,
    output logic [1:0]                  awburst,
    output logic [1:0]                  awlock,
    output logic [3:0]                  awcache,
    output logic [2:0]                  awprot,
    output logic                        awvalid,
    input  logic                        awready,
    output logic [3:0]                  wid,
    output logic [31:0]                 wdata_axi,
    output logic [3:0]                  wstrb,
    output logic                        wlast,
    output logic                        wvalid,
    input  logic                        wready,
    input  logic [3:0]                  bid,
    input  logic [1:0]                  bresp,
    input  logic                        bvalid,
    output logic                        bready
);
    localparam int CW = $clog2(MAX_RD + 1);
    localparam int WA = ADDR_W - 2;

    typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_RESP} w_state_t;

    w_state_t          w_state, w_next;
    logic              aw_pend, w_pend;
    logic [ADDR_W-1:0] w_addr;
    logic [2:0]        w_size;
    logic [31:0]       w_data;
    logic [3:0]        w_strb;
    logic [3:0]        w_port;
    logic              b_done;

    logic              ar_v;
    logic [ADDR_W-1:0] ar_addr;
    logic [2:0]        ar_size;
    logic [3:0]        ar_id;

    // Read table kept compacted and age-ordered: entry 0 is the oldest.
    logic [CW-1:0]     rd_cnt, rd_cnt_n, cnt_after;
    logic [MAX_RD-1:0] tbl_v, tbl_v_n, sh;
    logic [WA-1:0]     tbl_a [MAX_RD];
    logic [WA-1:0]     tbl_a_n [MAX_RD];
    logic [3:0]        tbl_p [MAX_RD];
    logic [3:0]        tbl_p_n [MAX_RD];
    logic              ret_hit, seen;

    logic [15:0]       elig;
    logic              a_hit, p_hit, w_busy;
    logic              gnt_any;
    logic [3:0]        gnt_idx;
    logic              g_wr;
    logic [2:0]        g_size;
    logic [ADDR_W-1:0] g_addr;
    logic [31:0]       g_wdata;
    logic              rd_acc, wr_acc;

    function automatic logic [2:0] axi_size(input logic [2:0] s);
        return (s == 3'b100 || s == 3'b101) ? 3'b010 : {1'b0, s[1:0]};
    endfunction

    function automatic logic [3:0] strb_dec(input logic [2:0] s, input logic [1:0] a);
        logic [3:0] m;
        m = 4'b0000;
        case (s)
            3'b000: m = 4'b0001 << a;
            3'b001: begin
                if (a == 2'd0)      m = 4'b0011;
                else if (a == 2'd2) m = 4'b1100;
            end
            3'b010: if (a == 2'd0) m = 4'b1111;
            3'b100: m = 4'b1111 >> (2'd3 - a);
            3'b101: m = 4'b1111 << a;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    always_comb begin
        elig   = '0;
        a_hit  = 1'b0;
        p_hit  = 1'b0;
        w_busy = (w_state != W_IDLE);
        for (int i = 0; i < NUM_PORTS; i++) begin
            a_hit = 1'b0;
            p_hit = 1'b0;
            for (int k = 0; k < MAX_RD; k++) begin
                if (tbl_v[k] && tbl_a[k] == addr[i*ADDR_W+2 +: WA]) a_hit = 1'b1;
                if (tbl_v[k] && tbl_p[k] == 4'(i))                   p_hit = 1'b1;
            end
            if (req[i]) begin
                if (wr[i])
                    elig[i] = !w_busy && !a_hit && !p_hit;
                else
                    elig[i] = !ar_v && (rd_cnt < CW'(MAX_RD)) &&
                              !(w_busy && (w_addr[ADDR_W-1:2] == addr[i*ADDR_W+2 +: WA] ||
                                           w_port == 4'(i)));
            end
        end
    end

`ifdef SRAM_AXI_RR_ARB_EN
    logic [3:0] rr_ptr;
    logic [4:0] rr_idx;

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        rr_idx  = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            rr_idx = {1'b0, rr_ptr} + 5'd1 + 5'(k);
            if (rr_idx >= 5'(NUM_PORTS)) rr_idx = rr_idx - 5'(NUM_PORTS);
            if (!gnt_any && elig[rr_idx[3:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = rr_idx[3:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn)      rr_ptr <= 4'(NUM_PORTS - 1);
        else if (gnt_any) rr_ptr <= gnt_idx;
    end
`else
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (elig[k]) begin
                gnt_any = 1'b1;
                gnt_idx = 4'(k);
            end
        end
    end
`endif

    always_comb begin
        addr_ok = '0;
        g_wr    = 1'b0;
        g_size  = '0;
        g_addr  = '0;
        g_wdata = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (gnt_any && gnt_idx == 4'(i)) begin
                addr_ok[i] = 1'b1;
                g_wr       = wr[i];
                g_size     = size[3*i +: 3];
                g_addr     = addr[i*ADDR_W +: ADDR_W];
                g_wdata    = wdata[32*i +: 32];
            end
        end
    end

    assign rd_acc = gnt_any && !g_wr;
    assign wr_acc = gnt_any && g_wr;

    // Retire the oldest entry for rid by shifting everything above it down one slot.
    always_comb begin
        tbl_v_n = tbl_v;
        tbl_a_n = tbl_a;
        tbl_p_n = tbl_p;
        seen    = 1'b0;
        sh      = '0;
        for (int k = 0; k < MAX_RD; k++) begin
            if (!seen && rvalid && tbl_v[k] && tbl_p[k] == rid) seen = 1'b1;
            sh[k] = seen;
        end
        ret_hit = seen;
        for (int k = 0; k < MAX_RD - 1; k++) begin
            if (sh[k]) begin
                tbl_v_n[k] = tbl_v[k+1];
                tbl_a_n[k] = tbl_a[k+1];
                tbl_p_n[k] = tbl_p[k+1];
            end
        end
        if (sh[MAX_RD-1]) tbl_v_n[MAX_RD-1] = 1'b0;
        cnt_after = rd_cnt - CW'(ret_hit);
        for (int k = 0; k < MAX_RD; k++) begin
            if (rd_acc && cnt_after == CW'(k)) begin
                tbl_v_n[k] = 1'b1;
                tbl_a_n[k] = g_addr[ADDR_W-1:2];
                tbl_p_n[k] = gnt_idx;
            end
        end
        rd_cnt_n = cnt_after + CW'(rd_acc);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tbl_v  <= '0;
            rd_cnt <= '0;
        end else begin
            tbl_v  <= tbl_v_n;
            rd_cnt <= rd_cnt_n;
        end
    end

    always_ff @(posedge clk) begin
        tbl_a <= tbl_a_n;
        tbl_p <= tbl_p_n;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ar_v    <= 1'b0;
            ar_addr <= '0;
            ar_size <= '0;
            ar_id   <= '0;
        end else if (ar_v) begin
            if (arready) ar_v <= 1'b0;
        end else if (rd_acc) begin
            ar_v    <= 1'b1;
            ar_addr <= g_addr;
            ar_size <= axi_size(g_size);
            ar_id   <= gnt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) w_state <= W_IDLE;
        else         w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (wr_acc) w_next = W_ISSUE;
            W_ISSUE: if ((!aw_pend || awready) && (!w_pend || wready)) w_next = W_RESP;
            W_RESP:  if (bvalid) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    assign b_done = (w_state == W_RESP) && bvalid;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            aw_pend <= 1'b0;
            w_pend  <= 1'b0;
            w_addr  <= '0;
            w_size  <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            w_port  <= '0;
        end else if (w_state == W_IDLE && wr_acc) begin
            aw_pend <= 1'b1;
            w_pend  <= 1'b1;
            w_addr  <= g_addr;
            w_size  <= axi_size(g_size);
            w_data  <= g_wdata;
            w_strb  <= strb_dec(g_size, g_addr[1:0]);
            w_port  <= gnt_idx;
        end else begin
            if (awready) aw_pend <= 1'b0;
            if (wready)  w_pend  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdata   <= '0;
            data_ok <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                data_ok[i] <= (ret_hit && rid == 4'(i)) || (b_done && w_port == 4'(i));
                if (ret_hit && rid == 4'(i)) rdata[32*i +: 32] <= rdata_axi;
            end
        end
    end

    assign arid      = ar_id;
    assign araddr    = ar_addr;
    assign arlen     = 4'd0;
    assign arsize    = ar_size;
    assign arburst   = 2'b01;
    assign arlock    = 2'b00;
    assign arcache   = 4'd0;
    assign arprot    = 3'd0;
    assign arvalid   = ar_v;
    assign rready    = 1'b1;
    assign awid      = w_port;
    assign awaddr    = w_addr;
    assign awlen     = 4'd0;
    assign awsize    = w_size;
    assign awburst   = 2'b01;
    assign awlock    = 2'b00;
    assign awcache   = 4'd0;
    assign awprot    = 3'd0;
    assign awvalid   = aw_pend;
    assign wid       = w_port;
    assign wdata_axi = w_data;
    assign wstrb     = w_strb;
    assign wlast     = 1'b1;
    assign wvalid    = w_pend;
    assign bready    = 1'b1;

    logic unused_ok;
    assign unused_ok = ^{rresp, rlast, bid, bresp, elig};
endmodule

// File: tb/tb_sram_axi_bridge_mp.sv
// tb/tb_sram_axi_bridge_mp.sv - directed self-checking bench for sram_axi_bridge_mp
module tb_sram_axi_bridge_mp;
    localparam int N  = 2;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic [N-1:0]    req, wr, addr_ok, data_ok;
    logic [3*N-1:0]  size;
    logic [AW*N-1:0] addr;
    logic [32*N-1:0] wdata, rdata;
    logic [3:0]      arid, arlen, arcache, rid, awid, awlen, awcache, wid, wstrb, bid;
    logic [AW-1:0]   araddr, awaddr;
    logic [2:0]      arsize, arprot, awsize, awprot;
    logic [1:0]      arburst, arlock, rresp, awburst, awlock, bresp;
    logic            arvalid, arready, rlast, rvalid, rready;
    logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [31:0]     rdata_axi, wdata_axi;

    int checks   = 0;
    int failures = 0;
    int acc_cnt, ar_cnt, gi, ai;
    logic [3:0] gnt_seq [4];
    logic [3:0] ar_seq  [4];
    logic [3:0] exp_seq [4];

    sram_axi_bridge_mp #(.NUM_PORTS(N), .ADDR_W(AW), .MAX_RD(4)) dut (
        .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .addr(addr),
        .wdata(wdata), .rdata(rdata), .addr_ok(addr_ok), .data_ok(data_ok),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata_axi(rdata_axi), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata_axi(wdata_axi), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int p, input logic r, input logic w, input logic [2:0] s,
                            input logic [31:0] a, input logic [31:0] d);
        req[p]           = r;
        wr[p]            = w;
        size[3*p +: 3]   = s;
        addr[AW*p +: AW] = a;
        wdata[32*p +: 32] = d;
    endtask

    task automatic wr_complete(input string tag, input logic [3:0] id, input logic [1:0] exp_ok);
        @(negedge clk);
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bid = id;
        @(negedge clk);
        bvalid = 1'b0;
        #1;
        chk(tag, data_ok, exp_ok);
    endtask

    initial begin
`ifdef SRAM_AXI_RR_ARB_EN
        exp_seq = '{4'd1, 4'd0, 4'd1, 4'd0};
`else
        exp_seq = '{4'd1, 4'd1, 4'd1, 4'd1};
`endif
        resetn = 1'b0;
        req = '0; wr = '0; size = '0; addr = '0; wdata = '0;
        arready = 1'b0; rid = '0; rdata_axi = '0; rresp = '0; rlast = 1'b1; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_data_ok", data_ok, 2'b00);
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_awvalid", awvalid, 1'b0);
        chk("rst_wvalid", wvalid, 1'b0);
        chk("rst_rdata", rdata, 64'h0);
        chk("rst_ready", {rready, bready}, 2'b11);
        resetn = 1'b1;

        // Single read on port 0
        @(negedge clk);
        set_port(0, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
        #1;
        chk("t1_addr_ok", addr_ok, 2'b01);
        @(negedge clk);
        set_port(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        arready = 1'b1;
        #1;
        chk("t1_arvalid", arvalid, 1'b1);
        chk("t1_araddr", araddr, 32'h100);
        chk("t1_arid", arid, 4'd0);
        chk("t1_arsize_len", {arsize, arlen}, {3'b010, 4'd0});
        @(negedge clk);
        arready = 1'b0;
        #1;
        chk("t1_ar_freed", arvalid, 1'b0);
        repeat (2) @(negedge clk);
        @(negedge clk);
        rvalid = 1'b1; rid = 4'd0; rdata_axi = 32'hDEADBEEF;
        #1;
        chk("t1_no_early_ok", data_ok, 2'b00);
        @(negedge clk);
        rvalid = 1'b0;
        #1;
        chk("t1_data_ok", data_ok, 2'b01);
        chk("t1_rdata", rdata[31:0], 32'hDEADBEEF);
        @(negedge clk);
        #1;
        chk("t1_pulse_end", data_ok, 2'b00);

        // Port 1 fills the read table while R is withheld
        @(negedge clk);
        arready = 1'b1;
        set_port(1, 1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
        acc_cnt = 0; ar_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (addr_ok[1]) acc_cnt++;
            if (arvalid && arready) ar_cnt++;
            @(negedge clk);
        end
        #1;
        chk("t2_accepts", acc_cnt, 4);
        chk("t2_ar_sent", ar_cnt, 4);
        chk("t2_blocked", addr_ok, 2'b00);
        rvalid = 1'b1; rid = 4'd1; rdata_axi = 32'hCAFE0001;
        #1;
        chk("t2_blocked_on_r", addr_ok, 2'b00);
        @(negedge clk);
        rvalid = 1'b0;
        #1;
        chk("t2_data_ok", data_ok, 2'b10);
        chk("t2_rdata", rdata[63:32], 32'hCAFE0001);
        chk("t2_unblocked", addr_ok, 2'b10);
        set_port(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            rvalid = 1'b1; rid = 4'd1; rdata_axi = 32'hCAFE0002 + 32'(j);
        end
        @(negedge clk);
        rvalid = 1'b0; arready = 1'b0;
        #1;
        chk("t2_drain_last", {data_ok, rdata[63:32]}, {2'b10, 32'hCAFE0004});

        // Write on port 1, then a read of the same word from port 0
        @(negedge clk);
        set_port(1, 1'b1, 1'b1, 3'b010, 32'h200, 32'h11223344);
        #1;
        chk("t3_wr_addr_ok", addr_ok, 2'b10);
        @(negedge clk);
        set_port(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        set_port(0, 1'b1, 1'b0, 3'b001, 32'h202, 32'h0);
        awready = 1'b1; wready = 1'b1;
        #1;
        chk("t3_hazard_issue", addr_ok, 2'b00);
        chk("t3_aw_w_valid", {awvalid, wvalid}, 2'b11);
        chk("t3_awaddr", awaddr, 32'h200);
        chk("t3_ids", {awid, wid}, 8'h11);
        chk("t3_wdata_strb", {wdata_axi, wstrb, awsize}, {32'h11223344, 4'b1111, 3'b010});
        @(negedge clk);
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bid = 4'd1;
        #1;
        chk("t3_aw_w_dropped", {awvalid, wvalid}, 2'b00);
        chk("t3_hazard_resp", addr_ok, 2'b00);
        @(negedge clk);
        bvalid = 1'b0;
        #1;
        chk("t3_data_ok", data_ok, 2'b10);
        chk("t3_read_released", addr_ok, 2'b01);
        set_port(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);

        // SB 0x55 at 0x303 on port 0
        @(negedge clk);
        set_port(0, 1'b1, 1'b1, 3'b000, 32'h303, 32'h55555555);
        #1;
        chk("t4_addr_ok", addr_ok, 2'b01);
        @(negedge clk);
        set_port(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        awready = 1'b1; wready = 1'b1;
        #1;
        chk("t4_wstrb", wstrb, 4'b1000);
        chk("t4_awsize", awsize, 3'b000);
        chk("t4_awaddr_id", {awaddr, awid}, {32'h303, 4'd0});
        wr_complete("t4_data_ok", 4'd0, 2'b01);

        // SWR at 0x301 on port 1
        @(negedge clk);
        set_port(1, 1'b1, 1'b1, 3'b101, 32'h301, 32'hA5A5A5A5);
        #1;
        chk("t5_addr_ok", addr_ok, 2'b10);
        @(negedge clk);
        set_port(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        awready = 1'b1; wready = 1'b1;
        #1;
        chk("t5_wstrb", wstrb, 4'b1110);
        chk("t5_awsize", awsize, 3'b010);
        wr_complete("t5_data_ok", 4'd1, 2'b10);

        // AW accepted late, W immediately
        @(negedge clk);
        set_port(0, 1'b1, 1'b1, 3'b010, 32'h500, 32'h600DF00D);
        #1;
        chk("t6_addr_ok", addr_ok, 2'b01);
        @(negedge clk);
        set_port(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        wready = 1'b1; awready = 1'b0;
        #1;
        chk("t6_both_valid", {awvalid, wvalid}, 2'b11);
        @(negedge clk);
        wready = 1'b0;
        #1;
        chk("t6_w_dropped", {awvalid, wvalid}, 2'b10);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            chk("t6_aw_held", awvalid, 1'b1);
        end
        @(negedge clk);
        awready = 1'b1;
        #1;
        chk("t6_aw_fifth", awvalid, 1'b1);
        @(negedge clk);
        awready = 1'b0;
        #1;
        chk("t6_aw_dropped", {awvalid, data_ok}, {1'b0, 2'b00});
        @(negedge clk);
        bvalid = 1'b1; bid = 4'd0;
        #1;
        chk("t6_no_early_ok", data_ok, 2'b00);
        @(negedge clk);
        bvalid = 1'b0;
        #1;
        chk("t6_data_ok", data_ok, 2'b01);
        @(negedge clk);
        #1;
        chk("t6_single_pulse", data_ok, 2'b00);

        // Both ports reading continuously
        @(negedge clk);
        arready = 1'b1;
        set_port(0, 1'b1, 1'b0, 3'b010, 32'h600, 32'h0);
        set_port(1, 1'b1, 1'b0, 3'b010, 32'h700, 32'h0);
        gi = 0; ai = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (addr_ok != 2'b00) begin
                if (gi < 4) gnt_seq[gi] = {3'b000, addr_ok[1]};
                gi++;
            end
            if (arvalid && arready) begin
                if (ai < 4) ar_seq[ai] = arid;
                ai++;
            end
            @(negedge clk);
        end
        #1;
        chk("t7_grant_count", gi, 4);
        chk("t7_ar_count", ai, 4);
        for (int k = 0; k < 4; k++) begin
            if (k < gi) chk($sformatf("t7_grant%0d", k), gnt_seq[k], exp_seq[k]);
            if (k < ai) chk($sformatf("t7_arid%0d", k), ar_seq[k], exp_seq[k]);
        end
        chk("t7_full", addr_ok, 2'b00);
        req = '0;
        arready = 1'b0;

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
